// File: rtl/imp_ln_pkg.sv
// Shared types and widths for the improved
// LayerNorm statistics front-end.
package imp_ln_pkg;

  localparam int DATA_W_D = 8;
  localparam int LOG2N_D  = 6;

  function automatic int sum_w(input int dw, input int l2n);
    return dw + l2n;
  endfunction

  function automatic int sq_w(input int dw, input int l2n);
    return 2 * dw - 1 + l2n;
  endfunction

  function automatic int var_w(input int dw);
    return 2 * dw - 1;
  endfunction

  localparam int SUM_W = sum_w(DATA_W_D, LOG2N_D);
  localparam int SQ_W  = sq_w(DATA_W_D, LOG2N_D);
  localparam int VAR_W = var_w(DATA_W_D);

  localparam int ADDR_LO = 64;
  localparam int ADDR_HI = 255;
  localparam int ADDR_W  = 8;
  localparam int EXP_W   = 4;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/imp_var_normalizer.sv
// Variance normaliser: shifts v by 2 bits per cycle
// into [ADDR_LO,ADDR_HI], tracking the exponent.
module imp_var_normalizer
  import imp_ln_pkg::*;
#(
  parameter int VW = VAR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VW-1:0]           var_in,
  output logic                    done,
  output logic [ADDR_W-1:0]       addr,
  output logic signed [EXP_W-1:0] exp_k,
  output logic                    zero
);

  localparam logic [VW-1:0] LO_V = VW'(ADDR_LO);
  localparam logic [VW-1:0] HI_V = VW'(ADDR_HI);

  logic [VW-1:0]           v;
  logic signed [EXP_W-1:0] k;
  logic                    busy;
  logic                    is_zero;
  logic                    is_hi;
  logic                    is_lo;

  // Classify the current value; zero is kept apart from "too small"
  always_comb begin
    is_zero = (v == '0);
    is_hi   = (v > HI_V);
    is_lo   = !is_zero && (v < LO_V);
    done    = busy && !is_hi && !is_lo;
    zero    = is_zero;
    addr    = is_zero ? '0 : v[ADDR_W-1:0];
    exp_k   = is_zero ? '0 : k;
  end

  // One shift-or-finish decision per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= '0;
      k    <= '0;
      busy <= 1'b0;
    end else if (start) begin
      v    <= var_in;
      k    <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      unique case (1'b1)
        is_hi: begin
          v <= v >> 2;
          k <= k + 4'sd1;
        end
        is_lo: begin
          v <= v << 2;
          k <= k - 4'sd1;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/imp_var_norm.sv
// Accumulates N samples, derives mean and variance,
// and hands the variance to the normaliser.
module imp_var_norm
  import imp_ln_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LOG2N  = LOG2N_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_mean,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [EXP_W-1:0]    out_exp,
  output logic                out_zero
);

  localparam int SW = sum_w(DATA_W, LOG2N);
  localparam int QW = sq_w(DATA_W, LOG2N);
  localparam int VW = var_w(DATA_W);
  localparam int PW = 2 * DATA_W;

  state_t state;
  state_t nstate;

  logic signed [SW-1:0]     sum;
  logic [QW-1:0]            sumsq;
  logic [LOG2N-1:0]         count;
  logic                     beat;
  logic                     last;
  logic                     start;

  logic signed [PW-1:0]     sq;
  logic signed [SW-1:0]     mean_full;
  logic signed [DATA_W-1:0] mean_c;
  logic [QW-1:0]            ex2_full;
  logic [VW-1:0]            ex2;
  logic signed [PW-1:0]     mm;
  logic signed [VW+1:0]     diff;
  logic [VW-1:0]            var_c;

  logic                     n_done;
  logic [ADDR_W-1:0]        n_addr;
  logic signed [EXP_W-1:0]  n_exp;
  logic                     n_zero;

  assign beat = in_valid && in_ready;
  assign last = (count == {LOG2N{1'b1}});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      ACC:  if (beat && last) nstate = CALC;
      CALC: nstate = NORM;
      NORM: if (n_done) nstate = OUT;
      OUT:  if (out_ready) nstate = ACC;
      default: nstate = ACC;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
    start     = (state == CALC);
  end

  // Mean and clamped variance from the accumulators
  always_comb begin
    sq        = $signed(in_data) * $signed(in_data);
    mean_full = sum >>> LOG2N;
    mean_c    = mean_full[DATA_W-1:0];
    ex2_full  = sumsq >> LOG2N;
    ex2       = ex2_full[VW-1:0];
    mm        = mean_c * mean_c;
    diff      = $signed({2'b00, ex2}) - $signed({mm[PW-1], mm});
    var_c     = diff[VW+1] ? '0 : diff[VW-1:0];
  end

  // Sum, sum of squares and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      sumsq <= '0;
      count <= '0;
    end else if (state == OUT && out_ready) begin
      sum   <= '0;
      sumsq <= '0;
      count <= '0;
    end else if (beat) begin
      sum   <= sum + {{LOG2N{in_data[DATA_W-1]}}, in_data};
      sumsq <= sumsq + {{LOG2N{1'b0}}, sq[PW-2:0]};
      count <= count + 1'b1;
    end
  end

  // Registered result fields
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mean <= '0;
      out_addr <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
    end else begin
      if (start) out_mean <= mean_c;
      if (n_done) begin
        out_addr <= n_addr;
        out_exp  <= n_exp;
        out_zero <= n_zero;
      end
    end
  end

  imp_var_normalizer #(
    .VW(VW)
  ) u_norm (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .var_in (var_c),
    .done   (n_done),
    .addr   (n_addr),
    .exp_k  (n_exp),
    .zero   (n_zero)
  );

endmodule

// File: tb/tb_imp_var_norm.sv
// Self-checking bench for imp_var_norm.
// Table vectors, scoreboard queue, corner sequences.
module tb_imp_var_norm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_mean;
  logic [7:0] out_addr;
  logic [3:0] out_exp;
  logic       out_zero;

  always #5 clk = ~clk;

  imp_var_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_addr  (out_addr),
    .out_exp   (out_exp),
    .out_zero  (out_zero)
  );

  typedef struct {
    int pat;
    int mean;
    int addr;
    int ex;
    int zero;
    int lat;
  } vec_t;

  typedef struct {
    int mean;
    int addr;
    int ex;
    int zero;
    int lat;
  } res_t;

  int   total = 0;
  int   bad = 0;
  res_t sb[$];
  int   rnd[64];
  vec_t tbl[5];

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int samp(input int pat, input int i);
    case (pat)
      0: return 0;
      1: return (i % 2 == 0) ? 8 : -8;
      2: return (i < 32) ? 127 : -128;
      3: return (i < 32) ? 1 : -1;
      4: return (i == 63) ? -1 : 0;
      5: return 3;
      default: return rnd[i];
    endcase
  endfunction

  function automatic res_t model(input int pat);
    res_t r;
    int s, q, m, v, k, sh;
    s = 0;
    q = 0;
    for (int i = 0; i < 64; i++) begin
      s += samp(pat, i);
      q += samp(pat, i) * samp(pat, i);
    end
    m = (s >= 0) ? s / 64 : -((-s + 63) / 64);
    v = q / 64 - m * m;
    if (v < 0) v = 0;
    k = 0;
    sh = 0;
    while (v != 0 && (v > 255 || v < 64)) begin
      if (v > 255) begin v = v / 4; k++; end
      else begin v = v * 4; k--; end
      sh++;
    end
    r.mean = m;
    r.zero = (v == 0) ? 1 : 0;
    r.addr = v;
    r.ex = (v == 0) ? 0 : k;
    r.lat = 3 + sh;
    return r;
  endfunction

  task automatic drive(input int pat, input bit gaps, input res_t e);
    for (int i = 0; i < 64; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = 8'(samp(pat, i));
      if (i == 63) sb.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input string nm);
    int   edges;
    res_t e;
    edges = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      if (edges > 20) break;
      @(posedge clk);
      edges++;
    end
    check({nm, " out_valid seen"}, int'(out_valid), 1);
    if (sb.size() == 0) begin
      check({nm, " scoreboard entry"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({nm, " latency"}, edges, e.lat);
    check({nm, " mean"}, int'($signed(out_mean)), e.mean);
    check({nm, " addr"}, int'(out_addr), e.addr);
    check({nm, " exp"}, int'($signed(out_exp)), e.ex);
    check({nm, " zero"}, int'(out_zero), e.zero);
  endtask

  task automatic consume(input string nm, input int hold);
    logic [7:0] m0, a0;
    logic [3:0] x0;
    logic       z0;
    m0 = out_mean;
    a0 = out_addr;
    x0 = out_exp;
    z0 = out_zero;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({nm, " hold valid"}, int'(out_valid), 1);
      check({nm, " hold in_ready"}, int'(in_ready), 0);
      check({nm, " hold stable"},
            int'({out_mean, out_addr, out_exp, out_zero}),
            int'({m0, a0, x0, z0}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd100;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, " valid drop"}, int'(out_valid), 0);
    check({nm, " ready back"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string nm, input int pat,
                     input bit gaps, input res_t e, input int hold);
    drive(pat, gaps, e);
    collect(nm);
    consume(nm, hold);
  endtask

  initial begin
    res_t e;
    tbl[0] = '{pat: 0, mean: 0, addr: 0, ex: 0, zero: 1, lat: 3};
    tbl[1] = '{pat: 1, mean: 0, addr: 64, ex: 0, zero: 0, lat: 3};
    tbl[2] = '{pat: 2, mean: -1, addr: 253, ex: 3, zero: 0, lat: 6};
    tbl[3] = '{pat: 3, mean: 0, addr: 64, ex: -3, zero: 0, lat: 6};
    tbl[4] = '{pat: 4, mean: -1, addr: 0, ex: 0, zero: 1, lat: 3};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset mean", int'(out_mean), 0);
    check("reset addr", int'(out_addr), 0);
    check("reset exp", int'(out_exp), 0);
    check("reset zero", int'(out_zero), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      e = '{mean: tbl[i].mean, addr: tbl[i].addr, ex: tbl[i].ex,
            zero: tbl[i].zero, lat: tbl[i].lat};
      run($sformatf("vec%0d", i), tbl[i].pat, 1'b0, e,
          (i == 2) ? 5 : 1);
    end

    e = '{mean: tbl[2].mean, addr: tbl[2].addr, ex: tbl[2].ex,
          zero: tbl[2].zero, lat: tbl[2].lat};
    run("gaps2", 2, 1'b1, e, 1);
    e = '{mean: tbl[3].mean, addr: tbl[3].addr, ex: tbl[3].ex,
          zero: tbl[3].zero, lat: tbl[3].lat};
    run("gaps3", 3, 1'b1, e, 0);

    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'd127;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = '{mean: 3, addr: 0, ex: 0, zero: 1, lat: 3};
    run("rst_acc", 5, 1'b0, e, 1);

    drive(2, 1'b0, model(2));
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_norm out_valid", int'(out_valid), 0);
    check("rst_norm in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run("post_rst", 1, 1'b0, model(1), 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++)
        rnd[i] = $urandom_range(0, 255) - 128;
      if (r == 1)
        for (int i = 0; i < 64; i++) rnd[i] = rnd[i] / 16;
      run($sformatf("rand%0d", r), 6, 1'b1, model(6), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imp_var_norm.md
# imp_var_norm

Statistics front-end for the improved LayerNorm datapath. It accepts a vector of N signed samples over a valid/ready stream and accumulates the sum and the sum of squares. It then computes the mean and the variance, and normalises the variance into an 8-bit square-root LUT address plus an even power-of-two exponent. The downstream sqrt LUT consumes `out_addr`, and the std-scaling stage consumes `out_exp`, `out_mean` and `out_zero`.

## Interface
- `DATA_W`, 8: sample width, signed two's complement.
- `LOG2N`, 6: log2 of vector length; N = 2^LOG2N samples per vector.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  block accepts a sample.
- `in_data`  in  DATA_W  signed sample.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  downstream accepts the result.
- `out_mean`  out  DATA_W  signed mean, floor(sum / N).
- `out_addr`  out  8  normalised variance, in [64,255] unless zero.
- `out_exp`  out  4  signed k; sqrt(var) = LUT(out_addr) * 2^k / 16.
- `out_zero`  out  1  variance is 0 after clamping.

## Operation
- FSM states: ACC, CALC, NORM, OUT. Reset enters ACC.
- **ACC**
  - `in_ready` = 1.
  - Each in_valid & in_ready beat: sum += x (DATA_W+LOG2N bits, signed); sumsq += x*x (2*DATA_W-1+LOG2N bits, unsigned); count += 1.
  - On the N-th beat go to CALC.
- **CALC** (1 cycle)
  - mean = sum >>> LOG2N (arithmetic, floor).
  - ex2 = sumsq >> LOG2N.
  - var = ex2 - mean*mean, computed signed. A negative result (floor artefact) clamps to 0.
  - var is registered as v (2*DATA_W-1 bits); k is set to 0. Go to NORM.
- **NORM** (one test per cycle)
  - v == 0: addr = 0, exp = 0, zero = 1; go to OUT.
  - v > 255: v >>= 2, k += 1; stay.
  - v < 64: v <<= 2, k -= 1; stay.
  - Otherwise addr = v[7:0], exp = k, zero = 0; go to OUT.
  - For DATA_W = 8 this takes at most 4 cycles; k stays in [-3,+3].
- **OUT**
  - `out_valid` = 1; all outputs are registered and stable.
  - On out_ready, clear sum, sumsq and count, and go to ACC.
- `in_ready` = 0 in CALC, NORM and OUT; no sample is accepted while a result is pending.

## Timing
- Reset values:
  - `out_valid`, `out_mean`, `out_addr`, `out_exp`, `out_zero` = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
  - Accumulators and count = 0.
- Latency: last beat accepted in cycle t; CALC at t+1; NORM from t+2 for S+1 cycles (S = number of shifts); `out_valid` first high at t+3+S.
  - Zero or in-range variance: t+3.
  - Maximum: t+6.
- Handshake:
  - Result transfers in the cycle where out_valid & out_ready.
  - `in_ready` goes high the next cycle.
  - A sample presented in the transfer cycle is not accepted.
- Backpressure: outputs hold indefinitely while out_ready = 0.
- Reset mid-operation, in any state: discard partial accumulation and any pending result; return to ACC with counters cleared.
- Gaps in in_valid during ACC only stall accumulation; there is no timeout.

## Structure
- Shared package (`imp_ln_pkg`):
  - DATA_W and LOG2N defaults.
  - Derived widths: SUM_W, SQ_W, VAR_W.
  - ADDR_LO = 64, ADDR_HI = 255.
  - Exponent width 4.
  - FSM state enum.
- One natural sub-module, `imp_var_normalizer`: the NORM shift/exponent loop with start/done.
- The accumulator and the FSM stay in the top.

## Test plan
- 64 × x=0 → out_zero=1, out_addr=0, out_exp=0, out_mean=0; out_valid at t+3.
- 32 × (+8), 32 × (−8), interleaved → mean 0, var 64 → out_addr=64, out_exp=0, out_zero=0; out_valid at t+3 (LUT 0x80 → std 8).
- 32 × (+127), 32 × (−128) → mean −1, var 16255 → out_addr=253, out_exp=+3; out_valid at t+6.
- 32 × (+1), 32 × (−1) → var 1 → out_addr=64, out_exp=−3, out_mean=0.
- 63 × 0 then one −1 → mean −1, var clamps from −1 to 0 → out_zero=1, out_mean=−1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
  - Random in_valid gaps in ACC → results unchanged.
  - Assert rst after 10 beats, then send 64 × (+3) → out_mean=3, out_zero=1.
